// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: integer register file with pending-write scoreboard and decode hazard detection
// Ports: clk/rst (async active-high); rs1/rs2 addr->data combinational reads; rs_use marks which
// reads decode needs; issue_en/issue_rd request an issue, issue_ok/stall answer it; wr_en/wr_addr/
// wr_data is the writeback port; flush clears all busy bits; busy_vec exposes the scoreboard.
module regfile_scoreboard #(
    parameter int XLEN = 32,
    parameter int NREGS = 32,
    parameter int AW = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    rs1_addr,
    input  logic [AW-1:0]    rs2_addr,
    output logic [XLEN-1:0]  rs1_data,
    output logic [XLEN-1:0]  rs2_data,
    input  logic [1:0]       rs_use,
    input  logic             issue_en,
    input  logic [AW-1:0]    issue_rd,
    output logic             issue_ok,
    output logic             stall,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [XLEN-1:0]  wr_data,
    input  logic             flush,
    output logic [NREGS-1:0] busy_vec
);
    logic [XLEN-1:0] regs [NREGS];
    logic [NREGS-1:0] busy, busy_nxt;
    logic hit1, hit2, hiti, wr_keep;
    // a forwarded writeback both supplies the data and retires the pending bit for this cycle
    always_comb begin
        hit1 = BYPASS && wr_en && wr_addr == rs1_addr;
        hit2 = BYPASS && wr_en && wr_addr == rs2_addr;
        hiti = BYPASS && wr_en && wr_addr == issue_rd;
        rs1_data = (rst || (ZERO_REG && rs1_addr == '0)) ? '0 : hit1 ? wr_data : regs[rs1_addr];
        rs2_data = (rst || (ZERO_REG && rs2_addr == '0)) ? '0 : hit2 ? wr_data : regs[rs2_addr];
        stall = !rst && ((rs_use[0] && busy[rs1_addr] && !hit1) ||
                         (rs_use[1] && busy[rs2_addr] && !hit2) ||
                         (issue_en && busy[issue_rd] && !hiti));
        issue_ok = !rst && issue_en && !stall;
        wr_keep = wr_en && !(ZERO_REG && wr_addr == '0);
        busy_nxt = busy;
        if (wr_en) busy_nxt[wr_addr] = 1'b0;
        if (issue_ok && !(ZERO_REG && issue_rd == '0)) busy_nxt[issue_rd] = 1'b1;
        if (flush) busy_nxt = '0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            busy <= '0;
        end else begin
            if (wr_keep) regs[wr_addr] <= wr_data;
            busy <= busy_nxt;
        end
    end
    assign busy_vec = busy;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: checks regfile_scoreboard in two configurations against a behavioural model
module tb_regfile_scoreboard;
    logic clk = 1'b0, rst = 1'b0;
    logic [4:0] rs1_addr = '0, rs2_addr = '0, issue_rd = '0, wr_addr = '0;
    logic [1:0] rs_use = '0;
    logic issue_en = 1'b0, wr_en = 1'b0, flush = 1'b0;
    logic [31:0] wr_data = '0;
    logic [31:0] o1 [2], o2 [2], obusy [2];
    logic ost [2], ook [2];
    int nchk = 0, nerr = 0;
    logic [31:0] m_regs [2][32];
    bit m_busy [2][32];

    always #5 clk = ~clk;

    regfile_scoreboard u0 (
        .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(o1[0]), .rs2_data(o2[0]), .rs_use(rs_use), .issue_en(issue_en),
        .issue_rd(issue_rd), .issue_ok(ook[0]), .stall(ost[0]), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .flush(flush), .busy_vec(obusy[0])
    );
    regfile_scoreboard #(.ZERO_REG(1'b0), .BYPASS(1'b0)) u1 (
        .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(o1[1]), .rs2_data(o2[1]), .rs_use(rs_use), .issue_en(issue_en),
        .issue_rd(issue_rd), .issue_ok(ook[1]), .stall(ost[1]), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .flush(flush), .busy_vec(obusy[1])
    );

    typedef struct {
        int unsigned we, wa, wd, a1, a2, ru, ie, ird, fl, e1, e2, est, eok, eb;
    } vec_t;
    vec_t tbl [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // instance 0: ZERO_REG=1 BYPASS=1, instance 1: ZERO_REG=0 BYPASS=0
    function automatic logic [31:0] m_rd(input int k, input logic [4:0] a);
        if (k == 0 && a == 0) return 32'h0;
        if (k == 0 && wr_en && wr_addr == a) return wr_data;
        return m_regs[k][a];
    endfunction

    function automatic bit m_eb(input int k, input logic [4:0] r);
        return m_busy[k][r] && !(k == 0 && wr_en && wr_addr == r);
    endfunction

    function automatic bit m_stall(input int k);
        return (rs_use[0] && m_eb(k, rs1_addr)) || (rs_use[1] && m_eb(k, rs2_addr)) ||
               (issue_en && m_eb(k, issue_rd));
    endfunction

    function automatic logic [31:0] m_bv(input int k);
        logic [31:0] v = '0;
        for (int r = 0; r < 32; r++) v[r] = m_busy[k][r];
        return v;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 2; k++)
            for (int r = 0; r < 32; r++) begin
                m_regs[k][r] = '0;
                m_busy[k][r] = 1'b0;
            end
    endtask

    task automatic m_edge();
        bit ok [2];
        for (int k = 0; k < 2; k++) ok[k] = issue_en && !m_stall(k);
        for (int k = 0; k < 2; k++) begin
            if (wr_en && !(k == 0 && wr_addr == 0)) m_regs[k][wr_addr] = wr_data;
            if (flush) begin
                for (int r = 0; r < 32; r++) m_busy[k][r] = 1'b0;
            end else begin
                if (wr_en) m_busy[k][wr_addr] = 1'b0;
                if (ok[k] && !(k == 0 && issue_rd == 0)) m_busy[k][issue_rd] = 1'b1;
            end
        end
    endtask

    task automatic check_model();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("u%0d rs1_data", k), o1[k], m_rd(k, rs1_addr));
            chk($sformatf("u%0d rs2_data", k), o2[k], m_rd(k, rs2_addr));
            chk($sformatf("u%0d stall", k), 32'(ost[k]), 32'(m_stall(k)));
            chk($sformatf("u%0d issue_ok", k), 32'(ook[k]), 32'(issue_en && !m_stall(k)));
            chk($sformatf("u%0d busy_vec", k), obusy[k], m_bv(k));
        end
    endtask

    task automatic pre();
        @(negedge clk);
        check_model();
    endtask

    task automatic post();
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; issue_en = 1'b0; flush = 1'b0; rs_use = '0;
    endtask

    function automatic logic [4:0] ra();
        return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
    endfunction

    initial begin
        //          we wa wd            a1 a2 ru ie ird fl e1            e2            st ok eb
        tbl[0]  = '{1, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0,  0, 0,            0,            0, 0, 0};
        tbl[1]  = '{0, 0, 0,            0, 0, 0, 0, 0,  0, 0,            0,            0, 0, 0};
        tbl[2]  = '{1, 5, 32'h12345678, 5, 5, 0, 0, 0,  0, 32'h12345678, 32'h12345678, 0, 0, 0};
        tbl[3]  = '{0, 0, 0,            5, 5, 0, 0, 0,  0, 32'h12345678, 32'h12345678, 0, 0, 0};
        tbl[4]  = '{1, 6, 32'hA5A5A5A5, 6, 5, 0, 0, 0,  0, 32'hA5A5A5A5, 32'h12345678, 0, 0, 0};
        tbl[5]  = '{0, 0, 0,            6, 5, 0, 1, 7,  0, 32'hA5A5A5A5, 32'h12345678, 0, 1, 0};
        tbl[6]  = '{0, 0, 0,            7, 5, 1, 0, 0,  0, 0,            32'h12345678, 1, 0, 32'h80};
        tbl[7]  = '{1, 7, 32'h55,       7, 5, 1, 0, 0,  0, 32'h55,       32'h12345678, 0, 0, 32'h80};
        tbl[8]  = '{0, 0, 0,            7, 5, 1, 0, 0,  0, 32'h55,       32'h12345678, 0, 0, 0};
        tbl[9]  = '{0, 0, 0,            9, 9, 0, 1, 9,  0, 0,            0,            0, 1, 0};
        tbl[10] = '{0, 0, 0,            9, 9, 0, 1, 9,  0, 0,            0,            1, 0, 32'h200};
        tbl[11] = '{1, 9, 32'h99,       9, 9, 0, 1, 9,  0, 32'h99,       32'h99,       0, 1, 32'h200};
        tbl[12] = '{0, 0, 0,            0, 0, 0, 1, 3,  0, 0,            0,            0, 1, 32'h200};
        tbl[13] = '{1, 3, 32'h33,       3, 3, 1, 1, 3,  0, 32'h33,       32'h33,       0, 1, 32'h208};
        tbl[14] = '{0, 0, 0,            3, 3, 0, 1, 4,  1, 32'h33,       32'h33,       0, 1, 32'h208};
        tbl[15] = '{0, 0, 0,            3, 3, 0, 0, 0,  0, 32'h33,       32'h33,       0, 0, 0};
        m_reset();
        #2 rst = 1'b1;
        #1;
        for (int a = 0; a < 32; a++) begin
            rs1_addr = 5'(a);
            rs2_addr = 5'(31 - a);
            #1;
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("rst u%0d rs1 x%0d", k, a), o1[k], 32'h0);
                chk($sformatf("rst u%0d rs2 x%0d", k, 31 - a), o2[k], 32'h0);
            end
        end
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst u%0d busy_vec", k), obusy[k], 32'h0);
            chk($sformatf("rst u%0d stall", k), 32'(ost[k]), 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) begin
            wr_en = tbl[i].we[0]; wr_addr = tbl[i].wa[4:0]; wr_data = tbl[i].wd;
            rs1_addr = tbl[i].a1[4:0]; rs2_addr = tbl[i].a2[4:0]; rs_use = tbl[i].ru[1:0];
            issue_en = tbl[i].ie[0]; issue_rd = tbl[i].ird[4:0]; flush = tbl[i].fl[0];
            pre();
            chk($sformatf("v%0d rs1_data", i), o1[0], tbl[i].e1);
            chk($sformatf("v%0d rs2_data", i), o2[0], tbl[i].e2);
            chk($sformatf("v%0d stall", i), 32'(ost[0]), tbl[i].est);
            chk($sformatf("v%0d issue_ok", i), 32'(ook[0]), tbl[i].eok);
            chk($sformatf("v%0d busy_vec", i), obusy[0], tbl[i].eb);
            post();
        end
        idle();
        wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'd7; issue_en = 1'b1; issue_rd = 5'd7;
        pre(); post();
        wr_en = 1'b0; issue_rd = 5'd9;
        pre(); post();
        idle();
        rs1_addr = 5'd2;
        @(negedge clk);
        chk("pre-reset busy_vec", obusy[0], 32'h280);
        chk("pre-reset x2", o1[0], 32'd7);
        #2;
        rst = 1'b1;
        issue_en = 1'b1; issue_rd = 5'd5; wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'hFF;
        rs_use = 2'b11; rs2_addr = 5'd7;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("async u%0d busy_vec", k), obusy[k], 32'h0);
            chk($sformatf("async u%0d x2", k), o1[k], 32'h0);
            chk($sformatf("async u%0d rs2", k), o2[k], 32'h0);
            chk($sformatf("async u%0d stall", k), 32'(ost[k]), 32'h0);
            chk($sformatf("async u%0d issue_ok", k), 32'(ook[k]), 32'h0);
        end
        m_reset();
        @(posedge clk);
        #1;
        chk("in-reset busy_vec", obusy[0], 32'h0);
        @(negedge clk);
        idle();
        rst = 1'b0;
        @(posedge clk);
        #1;
        rs2_addr = 5'd2;
        pre(); post();
        for (int n = 0; n < 3000; n++) begin
            wr_en = 1'($urandom_range(0, 1)); wr_addr = ra(); wr_data = $urandom;
            rs1_addr = ra(); rs2_addr = ra(); rs_use = 2'($urandom_range(0, 3));
            issue_en = 1'($urandom_range(0, 1)); issue_rd = ra();
            flush = ($urandom_range(0, 15) == 0);
            pre(); post();
        end
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
